// File: rtl/clk_div_gen.sv
// NCH-channel programmable clock divider / tick generator with glitch-free divisor reload.
// Optional legacy pass-through is enabled by defining CLK_DIV_BYPASS_EN (adds bypass_i).
module clk_div_gen #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 50000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH*CNT_W-1:0] div_i,
  input  logic [NCH-1:0]       div_ld_i,
`ifdef CLK_DIV_BYPASS_EN
  input  logic [NCH-1:0]       bypass_i,
`endif
  output logic [NCH-1:0]       clk_div_o,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       pend_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] ld_val;
    logic             pend;
    logic             clk_r;
    logic             tick_r;
    logic             last;
    logic             boundary;

    assign ld_val   = (div_i[k*CNT_W +: CNT_W] < MIN_DIV) ? MIN_DIV : div_i[k*CNT_W +: CNT_W];
    assign last     = (cnt == div_q - ONE);
    // A disabled channel is always at a period boundary, so reloads apply at once.
    assign boundary = !en_i[k] || last;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt      <= '0;
        div_q    <= DEF_DIV_W;
        pend_val <= DEF_DIV_W;
        pend     <= 1'b0;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        if (en_i[k]) begin
          cnt    <= last ? '0 : cnt + ONE;
          tick_r <= last;
          clk_r  <= (cnt < (div_q >> 1));
        end else begin
          cnt    <= '0;
          tick_r <= 1'b0;
          clk_r  <= 1'b0;
        end

        // Old divisor still governs this edge; the new one starts from cnt=0.
        if (div_ld_i[k]) begin
          if (boundary) begin
            div_q <= ld_val;
            pend  <= 1'b0;
          end else begin
            pend_val <= ld_val;
            pend     <= 1'b1;
          end
        end else if (pend && boundary) begin
          div_q <= pend_val;
          pend  <= 1'b0;
        end
      end
    end

    assign pend_o[k] = pend;
`ifdef CLK_DIV_BYPASS_EN
    assign clk_div_o[k] = bypass_i[k] ? clk_i   : clk_r;
    assign tick_o[k]    = bypass_i[k] ? en_i[k] : tick_r;
`else
    assign clk_div_o[k] = clk_r;
    assign tick_o[k]    = tick_r;
`endif
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with DEF_DIV=4; expected sequences are hand-computed per edge.
module tb_clk_div_gen;

  localparam int NCH   = 2;
  localparam int CNT_W = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NCH-1:0]       en_i;
  logic [NCH*CNT_W-1:0] div_i;
  logic [NCH-1:0]       div_ld_i;
`ifdef CLK_DIV_BYPASS_EN
  logic [NCH-1:0]       bypass_i = '0;
`endif
  logic [NCH-1:0]       clk_div_o;
  logic [NCH-1:0]       tick_o;
  logic [NCH-1:0]       pend_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  clk_div_gen #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .div_i    (div_i),
    .div_ld_i (div_ld_i),
`ifdef CLK_DIV_BYPASS_EN
    .bypass_i (bypass_i),
`endif
    .clk_div_o(clk_div_o),
    .tick_o   (tick_o),
    .pend_o   (pend_o)
  );

  // Advance one rising edge; outputs are sampled 1 ns later, inputs changed there too.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = '0; div_i = '0; div_ld_i = '0;
    #3;
    total++; if (clk_div_o !== 2'b00) begin bad++; $display("FAIL reset_clk got=%b exp=00", clk_div_o); end
    total++; if (tick_o !== 2'b00) begin bad++; $display("FAIL reset_tick got=%b exp=00", tick_o); end
    total++; if (pend_o !== 2'b00) begin bad++; $display("FAIL reset_pend got=%b exp=00", pend_o); end
    step();
    rst_i = 1'b0;
    en_i  = 2'b11;
  endtask

  // Edges e1..e8, both channels on DEF_DIV=4.
  task automatic test_default();
    logic [7:0] clk_t  = 8'b0011_0011;
    logic [7:0] tick_t = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (clk_div_o !== {2{clk_t[i]}}) begin bad++; $display("FAIL default_clk e=%0d got=%b exp=%b", i+1, clk_div_o, {2{clk_t[i]}}); end
      total++; if (tick_o !== {2{tick_t[i]}}) begin bad++; $display("FAIL default_tick e=%0d got=%b exp=%b", i+1, tick_o, {2{tick_t[i]}}); end
    end
  endtask

  // Edges e9..e17: ch0 loads 5 mid-period, ch1 keeps N=4.
  task automatic test_load5();
    logic [1:0] clk_t  [9] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10};
    logic [1:0] tick_t [9] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    logic [1:0] pend_t [9] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    div_i    = {16'd0, 16'd5};
    div_ld_i = 2'b01;
    for (int i = 0; i < 9; i++) begin
      step();
      div_ld_i = 2'b00;
      total++; if (clk_div_o !== clk_t[i]) begin bad++; $display("FAIL load5_clk e=%0d got=%b exp=%b", i+9, clk_div_o, clk_t[i]); end
      total++; if (tick_o !== tick_t[i]) begin bad++; $display("FAIL load5_tick e=%0d got=%b exp=%b", i+9, tick_o, tick_t[i]); end
      total++; if (pend_o !== pend_t[i]) begin bad++; $display("FAIL load5_pend e=%0d got=%b exp=%b", i+9, pend_o, pend_t[i]); end
    end
  endtask

  // Edges e18..e31: ch1 disabled, ch0 loads 7 then 9; only 9 is ever used.
  task automatic test_last_wins();
    logic [13:0] clk_t  = 14'b00000_1111_00011;
    logic [13:0] tick_t = 14'b10000_0000_10000;
    logic [13:0] pend_t = 14'b00000_0000_01111;
    en_i     = 2'b01;
    div_i    = {16'd0, 16'd7};
    div_ld_i = 2'b01;
    for (int i = 0; i < 14; i++) begin
      step();
      div_i    = {16'd0, 16'd9};
      div_ld_i = (i == 0) ? 2'b01 : 2'b00;
      total++; if (clk_div_o !== {1'b0, clk_t[i]}) begin bad++; $display("FAIL last_wins_clk e=%0d got=%b exp=%b", i+18, clk_div_o, {1'b0, clk_t[i]}); end
      total++; if (tick_o !== {1'b0, tick_t[i]}) begin bad++; $display("FAIL last_wins_tick e=%0d got=%b exp=%b", i+18, tick_o, {1'b0, tick_t[i]}); end
      total++; if (pend_o !== {1'b0, pend_t[i]}) begin bad++; $display("FAIL last_wins_pend e=%0d got=%b exp=%b", i+18, pend_o, {1'b0, pend_t[i]}); end
    end
  endtask

  // Edges e32..e43: load 3 exactly on the cnt==N-1 edge (e40).
  task automatic test_boundary_load();
    logic [3:0] clk_t  = 4'b0010;
    logic [3:0] tick_t = 4'b1001;
    for (int i = 0; i < 7; i++) step();
    div_i = {16'd0, 16'd3};
    step();
    div_ld_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step();
      div_ld_i = 2'b00;
      total++; if (clk_div_o !== {1'b0, clk_t[i]}) begin bad++; $display("FAIL bnd_clk e=%0d got=%b exp=%b", i+40, clk_div_o, {1'b0, clk_t[i]}); end
      total++; if (tick_o !== {1'b0, tick_t[i]}) begin bad++; $display("FAIL bnd_tick e=%0d got=%b exp=%b", i+40, tick_o, {1'b0, tick_t[i]}); end
      total++; if (pend_o !== 2'b00) begin bad++; $display("FAIL bnd_pend e=%0d got=%b exp=00", i+40, pend_o); end
    end
  endtask

  // Edges e44..e52: load 0 then 1, both clamp to N=2.
  task automatic test_clamp();
    logic [8:0] clk_t  = 9'b010101001;
    logic [8:0] tick_t = 9'b101010100;
    logic [8:0] pend_t = 9'b000000011;
    div_i    = {16'd0, 16'd0};
    div_ld_i = 2'b01;
    for (int i = 0; i < 9; i++) begin
      step();
      div_i    = {16'd0, 16'd1};
      div_ld_i = (i == 0) ? 2'b01 : 2'b00;
      total++; if (clk_div_o !== {1'b0, clk_t[i]}) begin bad++; $display("FAIL clamp_clk e=%0d got=%b exp=%b", i+44, clk_div_o, {1'b0, clk_t[i]}); end
      total++; if (tick_o !== {1'b0, tick_t[i]}) begin bad++; $display("FAIL clamp_tick e=%0d got=%b exp=%b", i+44, tick_o, {1'b0, tick_t[i]}); end
      total++; if (pend_o !== {1'b0, pend_t[i]}) begin bad++; $display("FAIL clamp_pend e=%0d got=%b exp=%b", i+44, pend_o, {1'b0, pend_t[i]}); end
    end
  endtask

  // Edges e53..e56: drop enable mid-period at e54, re-enable at e55.
  task automatic test_en_drop();
    logic [3:0] clk_t  = 4'b0101;
    logic [3:0] tick_t = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      en_i = (i == 0) ? 2'b00 : 2'b01;
      total++; if (clk_div_o !== {1'b0, clk_t[i]}) begin bad++; $display("FAIL endrop_clk e=%0d got=%b exp=%b", i+53, clk_div_o, {1'b0, clk_t[i]}); end
      total++; if (tick_o !== {1'b0, tick_t[i]}) begin bad++; $display("FAIL endrop_tick e=%0d got=%b exp=%b", i+53, tick_o, {1'b0, tick_t[i]}); end
    end
  endtask

  // Pending load of 8 is discarded by a mid-cycle reset; DEF_DIV=4 resumes.
  task automatic test_reset_mid();
    logic [3:0] clk_t  = 4'b0011;
    logic [3:0] tick_t = 4'b1000;
    div_i    = {16'd0, 16'd8};
    div_ld_i = 2'b01;
    step();
    div_ld_i = 2'b00;
    total++; if (pend_o !== 2'b01) begin bad++; $display("FAIL rstmid_pend_before got=%b exp=01", pend_o); end
    total++; if (clk_div_o !== 2'b01) begin bad++; $display("FAIL rstmid_clk_before got=%b exp=01", clk_div_o); end
    #2 rst_i = 1'b1;
    #1;
    total++; if (clk_div_o !== 2'b00) begin bad++; $display("FAIL rstmid_clk got=%b exp=00", clk_div_o); end
    total++; if (pend_o !== 2'b00) begin bad++; $display("FAIL rstmid_pend got=%b exp=00", pend_o); end
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (clk_div_o !== {1'b0, clk_t[i]}) begin bad++; $display("FAIL rstmid_run_clk i=%0d got=%b exp=%b", i, clk_div_o, {1'b0, clk_t[i]}); end
      total++; if (tick_o !== {1'b0, tick_t[i]}) begin bad++; $display("FAIL rstmid_run_tick i=%0d got=%b exp=%b", i, tick_o, {1'b0, tick_t[i]}); end
      total++; if (pend_o !== 2'b00) begin bad++; $display("FAIL rstmid_run_pend i=%0d got=%b exp=00", i, pend_o); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load5();
    test_last_wins();
    test_boundary_load();
    test_clamp();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
